// File: rtl/sprite_grid_move.sv
// Grid-locked sprite motion controller: fixed-point position, per-frame step,
// turns queued until tile-aligned (reversals immediate), wall stop, optional tunnel wrap.
module sprite_grid_move #(
  parameter int INITIAL_X = 288,
  parameter int INITIAL_Y = 384,
  parameter int SPEED     = 128,
  parameter int FP_SHIFT  = 6,
  parameter int GRID      = 32,
  parameter int OBJ_W     = 32,
  parameter int OBJ_H     = 32,
  parameter int FRAME_W   = 640,
  parameter int FRAME_H   = 480,
  parameter int WRAP_EN   = 1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic [3:0]         dir_req,
  input  logic               collision,
  input  logic [3:0]         HitEdgeCode,
  input  logic               restart,
  input  logic               freeze,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic [1:0]         heading,
  output logic               moving
);

  localparam int FP_ONE     = 2 ** FP_SHIFT;
  localparam int X_INIT     = INITIAL_X * FP_ONE;
  localparam int Y_INIT     = INITIAL_Y * FP_ONE;
  localparam int X_MAX      = (FRAME_W - OBJ_W) * FP_ONE;
  localparam int Y_MAX      = (FRAME_H - OBJ_H) * FP_ONE;
  localparam int ALIGN_MASK = GRID * FP_ONE - 1;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [2:0] {
    IDLE_ST,
    MOVE_ST,
    WAIT_FOR_EOF_ST,
    TURN_ST,
    POSITION_CHANGE_ST,
    POSITION_LIMITS_ST
  } state_t;

  state_t             state;
  logic signed [31:0] xpos;
  logic signed [31:0] ypos;
  logic               pend_vld;
  logic [1:0]         pend_dir;

  logic [1:0]         req_dir_c;
  logic               aligned_c;
  logic               edge_hit_c;
  logic               turn_ok_c;

  // Pixel outputs are the integer part of the fixed-point position registers
  assign topLeftX = 11'(xpos >>> FP_SHIFT);
  assign topLeftY = 11'(ypos >>> FP_SHIFT);

  // Request priority encode: up > down > left > right
  always_comb begin
    req_dir_c = DIR_RIGHT;
    if (dir_req[0])      req_dir_c = DIR_UP;
    else if (dir_req[1]) req_dir_c = DIR_DOWN;
    else if (dir_req[2]) req_dir_c = DIR_LEFT;
  end

  // Tile alignment, wall-edge match against heading, and turn acceptance
  always_comb begin
    aligned_c  = ((xpos & ALIGN_MASK) == 32'sd0) && ((ypos & ALIGN_MASK) == 32'sd0);
    edge_hit_c = 1'b0;
    case (heading)
      DIR_UP:    edge_hit_c = HitEdgeCode[2];
      DIR_DOWN:  edge_hit_c = HitEdgeCode[0];
      DIR_LEFT:  edge_hit_c = HitEdgeCode[3];
      DIR_RIGHT: edge_hit_c = HitEdgeCode[1];
    endcase
    // Opposite directions differ only in bit 0 of the encoding
    turn_ok_c = pend_vld && ((pend_dir == (heading ^ 2'd1)) || aligned_c);
  end

  // Frame-sequenced motion FSM with pending-request capture
  always_ff @(posedge clk) begin
    if (!resetN || restart) begin
      state    <= IDLE_ST;
      xpos     <= 32'(X_INIT);
      ypos     <= 32'(Y_INIT);
      heading  <= DIR_RIGHT;
      moving   <= 1'b0;
      pend_vld <= 1'b0;
      pend_dir <= DIR_UP;
    end else if (!freeze) begin
      case (state)
        IDLE_ST: begin
          xpos     <= 32'(X_INIT);
          ypos     <= 32'(Y_INIT);
          heading  <= DIR_RIGHT;
          moving   <= 1'b0;
          pend_vld <= 1'b0;
          if (startOfFrame) state <= MOVE_ST;
        end
        MOVE_ST: begin
          if (collision && edge_hit_c) begin
            moving <= 1'b0;
            state  <= WAIT_FOR_EOF_ST;
          end
          if (startOfFrame) state <= TURN_ST;
        end
        WAIT_FOR_EOF_ST: begin
          if (startOfFrame) state <= TURN_ST;
        end
        TURN_ST: begin
          if (turn_ok_c) begin
            heading  <= pend_dir;
            moving   <= 1'b1;
            pend_vld <= 1'b0;
          end
          state <= POSITION_CHANGE_ST;
        end
        POSITION_CHANGE_ST: begin
          if (moving) begin
            case (heading)
              DIR_UP:    ypos <= ypos - SPEED;
              DIR_DOWN:  ypos <= ypos + SPEED;
              DIR_LEFT:  xpos <= xpos - SPEED;
              DIR_RIGHT: xpos <= xpos + SPEED;
            endcase
          end
          state <= POSITION_LIMITS_ST;
        end
        POSITION_LIMITS_ST: begin
          if (ypos < 0) begin
            ypos   <= '0;
            moving <= 1'b0;
          end else if (ypos > Y_MAX) begin
            ypos   <= 32'(Y_MAX);
            moving <= 1'b0;
          end
          if (WRAP_EN != 0) begin
            if (xpos < 0)          xpos <= 32'(X_MAX);
            else if (xpos > X_MAX) xpos <= '0;
          end else begin
            if (xpos < 0) begin
              xpos   <= '0;
              moving <= 1'b0;
            end else if (xpos > X_MAX) begin
              xpos   <= 32'(X_MAX);
              moving <= 1'b0;
            end
          end
          state <= MOVE_ST;
        end
        default: state <= IDLE_ST;
      endcase
      // A fresh request overwrites any queued one, including one consumed this cycle
      if (state != IDLE_ST && dir_req != 4'd0) begin
        pend_vld <= 1'b1;
        pend_dir <= req_dir_c;
      end
    end
  end

endmodule

// File: tb/tb_sprite_grid_move.sv
// Bench for sprite_grid_move: wrap and clamp instances against a frame-timeline model.
module tb_sprite_grid_move;

  localparam int FP    = 64;
  localparam int SPD   = 128;
  localparam int TILE  = 32 * FP;
  localparam int XMAX  = (640 - 32) * FP;
  localparam int YMAX  = (480 - 32) * FP;

  logic              clk;
  logic              resetN;
  logic              startOfFrame;
  logic [3:0]        dir_req;
  logic              collision;
  logic [3:0]        HitEdgeCode;
  logic              restart;
  logic              freeze;
  logic signed [10:0] tlx [2];
  logic signed [10:0] tly [2];
  logic [1:0]        hd  [2];
  logic              mv  [2];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state per instance (0: wrap, 1: clamp)
  int   m_x   [2];
  int   m_y   [2];
  int   m_h   [2];
  bit   m_mov [2];
  bit   m_pv  [2];
  int   m_pd  [2];
  bit   m_run [2];
  int   m_ph  [2];   // cycles of the frame update still to go (0: waiting for a frame)

  sprite_grid_move #(.WRAP_EN(1)) dut0 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .dir_req(dir_req),
    .collision(collision), .HitEdgeCode(HitEdgeCode), .restart(restart), .freeze(freeze),
    .topLeftX(tlx[0]), .topLeftY(tly[0]), .heading(hd[0]), .moving(mv[0]));

  sprite_grid_move #(.WRAP_EN(0)) dut1 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .dir_req(dir_req),
    .collision(collision), .HitEdgeCode(HitEdgeCode), .restart(restart), .freeze(freeze),
    .topLeftX(tlx[1]), .topLeftY(tly[1]), .heading(hd[1]), .moving(mv[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_dir(input logic [3:0] d);
    for (int b = 0; b < 4; b++) if (d[b]) return b;
    return 0;
  endfunction

  function automatic bit wall_ahead(input int h, input logic [3:0] hit);
    int edge_of [4] = '{2, 0, 3, 1};
    return hit[edge_of[h]];
  endfunction

  task automatic model_init(input int i);
    m_x[i] = 288 * FP;  m_y[i] = 384 * FP;  m_h[i] = 3;  m_mov[i] = 0;
    m_pv[i] = 0;  m_pd[i] = 0;  m_run[i] = 0;  m_ph[i] = 0;
  endtask

  // One clock of sprite behaviour, written as a frame timeline
  task automatic model_edge(input int i);
    int opp [4] = '{1, 0, 3, 2};
    if (!resetN || restart) begin model_init(i); return; end
    if (freeze) return;
    if (!m_run[i]) begin
      if (startOfFrame) m_run[i] = 1;
      return;
    end
    case (m_ph[i])
      0: begin
        if (collision && wall_ahead(m_h[i], HitEdgeCode)) m_mov[i] = 0;
        if (startOfFrame) m_ph[i] = 3;
      end
      3: begin
        if (m_pv[i] && (m_pd[i] == opp[m_h[i]] ||
                        (m_x[i] % TILE == 0 && m_y[i] % TILE == 0))) begin
          m_h[i] = m_pd[i];  m_mov[i] = 1;  m_pv[i] = 0;
        end
        m_ph[i] = 2;
      end
      2: begin
        if (m_mov[i]) begin
          if (m_h[i] == 0) m_y[i] -= SPD;
          if (m_h[i] == 1) m_y[i] += SPD;
          if (m_h[i] == 2) m_x[i] -= SPD;
          if (m_h[i] == 3) m_x[i] += SPD;
        end
        m_ph[i] = 1;
      end
      default: begin
        if (m_y[i] < 0)         begin m_y[i] = 0;    m_mov[i] = 0; end
        else if (m_y[i] > YMAX) begin m_y[i] = YMAX; m_mov[i] = 0; end
        if (i == 0) begin
          if (m_x[i] < 0)         m_x[i] = XMAX;
          else if (m_x[i] > XMAX) m_x[i] = 0;
        end else begin
          if (m_x[i] < 0)         begin m_x[i] = 0;    m_mov[i] = 0; end
          else if (m_x[i] > XMAX) begin m_x[i] = XMAX; m_mov[i] = 0; end
        end
        m_ph[i] = 0;
      end
    endcase
    if (dir_req != 4'd0) begin m_pv[i] = 1; m_pd[i] = first_dir(dir_req); end
  endtask

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic compare_all();
    logic signed [10:0] ex, ey;
    for (int i = 0; i < 2; i++) begin
      ex = 11'(m_x[i] >>> 6);
      ey = 11'(m_y[i] >>> 6);
      chk($sformatf("x%0d", i), tlx[i], ex);
      chk($sformatf("y%0d", i), tly[i], ey);
      chk($sformatf("heading%0d", i), hd[i], m_h[i]);
      chk($sformatf("moving%0d", i), mv[i], m_mov[i]);
    end
  endtask

  task automatic tick(input logic sof, input logic [3:0] d, input logic col,
                      input logic [3:0] hit, input logic rs, input logic frz);
    startOfFrame = sof;  dir_req = d;  collision = col;
    HitEdgeCode = hit;   restart = rs;  freeze = frz;
    @(posedge clk);
    cyc++;
    model_edge(0);
    model_edge(1);
    #1;
    compare_all();
  endtask

  task automatic frame(input logic [3:0] d, input logic frz);
    tick(1'b1, d, 1'b0, 4'd0, 1'b0, frz);
    for (int c = 0; c < 7; c++) tick(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, frz);
  endtask

  initial begin
    resetN = 1'b0;  startOfFrame = 1'b0;  dir_req = 4'd0;  collision = 1'b0;
    HitEdgeCode = 4'd0;  restart = 1'b0;  freeze = 1'b0;
    model_init(0);  model_init(1);

    // Reset values
    tick(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("reset_x", tlx[0], 288);
    chk("reset_y", tly[0], 384);
    chk("reset_heading", hd[0], 3);
    chk("reset_moving", mv[0], 0);
    resetN = 1'b1;

    // Start, then ten frames without any request
    for (int f = 0; f < 11; f++) frame(4'd0, 1'b0);
    chk("idle_x", tlx[0], 288);

    // Right request: 2 px per frame
    tick(1'b0, 4'b1000, 1'b0, 4'd0, 1'b0, 1'b0);
    frame(4'd0, 1'b0);
    chk("right_x", tlx[0], 290);
    chk("right_moving", mv[0], 1);

    // Up request at X=290 waits for X=320
    tick(1'b0, 4'b0001, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int f = 0; f < 15; f++) frame(4'd0, 1'b0);
    chk("upwait_x", tlx[0], 320);
    chk("upwait_heading", hd[0], 3);
    frame(4'd0, 1'b0);
    chk("up_heading", hd[0], 0);
    chk("up_y", tly[0], 382);
    chk("up_x", tlx[0], 320);

    // Reversal at X=294 applies immediately
    tick(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    frame(4'd0, 1'b0);
    tick(1'b0, 4'b1000, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int f = 0; f < 3; f++) frame(4'd0, 1'b0);
    chk("rev_pre_x", tlx[0], 294);
    tick(1'b0, 4'b0100, 1'b0, 4'd0, 1'b0, 1'b0);
    frame(4'd0, 1'b0);
    chk("rev_x", tlx[0], 292);
    chk("rev_heading", hd[0], 2);

    // Wall on the right stops the sprite; a perpendicular turn waits for alignment
    tick(1'b0, 4'b1000, 1'b0, 4'd0, 1'b0, 1'b0);
    frame(4'd0, 1'b0);
    tick(1'b0, 4'd0, 1'b1, 4'b0010, 1'b0, 1'b0);
    chk("col_moving", mv[0], 0);
    tick(1'b0, 4'b0010, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int f = 0; f < 2; f++) frame(4'd0, 1'b0);
    chk("col_hold_x", tlx[0], 294);
    chk("col_hold_heading", hd[0], 3);
    chk("col_hold_moving", mv[0], 0);
    tick(1'b0, 4'b0100, 1'b0, 4'd0, 1'b0, 1'b0);
    frame(4'd0, 1'b0);
    chk("col_rev_x", tlx[0], 292);
    chk("col_rev_moving", mv[0], 1);

    // Left edge: wrap vs clamp
    tick(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    frame(4'd0, 1'b0);
    tick(1'b0, 4'b0100, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int f = 0; f < 144; f++) frame(4'd0, 1'b0);
    chk("edge_x_wrap", tlx[0], 0);
    chk("edge_x_clamp", tlx[1], 0);
    frame(4'd0, 1'b0);
    chk("wrap_x", tlx[0], 608);
    chk("wrap_moving", mv[0], 1);
    chk("clamp_x", tlx[1], 0);
    chk("clamp_moving", mv[1], 0);

    // Freeze holds through frame pulses; restart overrides freeze
    for (int f = 0; f < 5; f++) frame(4'b1000, 1'b1);
    chk("freeze_x", tlx[0], 608);
    chk("freeze_moving", mv[0], 1);
    tick(1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1);
    chk("frz_restart_x", tlx[0], 288);
    chk("frz_restart_y", tly[0], 384);
    chk("frz_restart_heading", hd[0], 3);
    chk("frz_restart_moving", mv[0], 0);
    frame(4'b1000, 1'b1);
    frame(4'd0, 1'b0);
    frame(4'd0, 1'b0);
    chk("after_freeze_x", tlx[0], 288);
    chk("after_freeze_moving", mv[0], 0);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      logic       r_sof, r_col, r_rs, r_frz;
      logic [3:0] r_dir, r_hit;
      r_sof = (c % 8 == 0) || ($urandom_range(0, 49) == 0);
      r_dir = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      r_col = ($urandom_range(0, 24) == 0);
      r_hit = 4'($urandom_range(0, 15));
      r_rs  = ($urandom_range(0, 799) == 0);
      r_frz = ($urandom_range(0, 19) == 0);
      tick(r_sof, r_dir, r_col, r_hit, r_rs, r_frz);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
